pseudocolor: RTL and testbench
==============================

Name: pseudocolor

Overview:
Inverse of the luminance/grayscale stage: maps a pixel's luminance back to RGB through a programmable 256-entry palette (false-colour / heat-map view).
- Sits in the per-pixel RGB filter chain, same r/g/b/en/pass_in interface as the other filters.
- Two-stage pipeline; 24-bit sideband is delay-matched.
- Palette loaded at run time over a valid/ready write port; self-initialised after reset.

Parameters:
COEF_R, 54, luminance weight for r (Q0.8)
COEF_G, 183, luminance weight for g (Q0.8)
COEF_B, 19, luminance weight for b (Q0.8); COEF_R+COEF_G+COEF_B must equal 256

Ports:
clk  input  1  pixel clock
rst  input  1  asynchronous, active-high reset
en  input  1  per-pixel enable: 1 = palette-mapped, 0 = bypass
r  input  8  red in
g  input  8  green in
b  input  8  blue in
pass_in  input  24  sideband in
outR  output  8  red out
outG  output  8  green out
outB  output  8  blue out
pass_thru  output  24  sideband out, aligned with outR/G/B
wr_valid  input  1  palette write request
wr_ready  output  1  palette write accept
wr_addr  input  8  palette index
wr_data  input  24  palette entry {R[23:16],G[15:8],B[7:0]}
busy  output  1  high while palette self-initialises

Behaviour:
- Reset is asynchronous and active-high: one clock, clk; reset port rst. While rst=1: outR/outG/outB=0, pass_thru=0, all pipeline registers 0, wr_ready=0, busy=1, FSM forced to INIT, init counter=0.
- Luminance: Y = (COEF_R*r + COEF_G*g + COEF_B*b) >> 8.
  - 16-bit unsigned sum; max 65280, so Y<=255 and no saturation is needed.
  - Y is the palette index.
- Pipeline, fixed latency 2 clocks input→output:
  - S1 registers Y, r, g, b, en, pass_in.
  - S2 is a synchronous palette read at S1.Y, plus registered copies of S1 r/g/b/en/pass_in.
  - Outputs = palette data when S2.en=1, else S2 r/g/b. pass_thru = S2.pass_in.
  - en travels with its pixel; toggling en never corrupts a pixel already in flight.
- Palette memory: 256x24, one write port and one read port.
  - Read-before-write: a read and a write to the same index in the same cycle return the old entry.
  - A write is visible to pixels entering S1 on the cycle after acceptance or later.
- FSM:
  - INIT: each cycle, write default entry at counter, counter+1. busy=1, wr_ready=0.
  - INIT → RUN after index 255 is written (256 cycles after rst deasserts).
  - RUN: busy=0, wr_ready=1. A write is accepted on wr_valid&&wr_ready, one entry per cycle, no back-pressure. wr_valid in INIT is ignored, not queued.
  - RUN has no exit except rst. rst mid-INIT restarts the counter at 0; rst in RUN re-enters INIT and discards the loaded palette.
- During INIT, pixels are forced to bypass regardless of en: outputs = delayed r/g/b, pass_thru still delayed 2.
- Default entry i (gray ramp) = {i,i,i}.

Optional Feature:
PSEUDOCOLOR_HEATMAP_INIT_EN.
- Defined: INIT writes a blue→green→red heat map instead of the gray ramp.
  - i<128: {0, 2i, 255-2i}
  - i>=128: {2i-255, 511-2i, 0}
  - e.g. entry 0=0x0000FF, 128=0x01FF00, 255=0xFF0100.
- Undefined: INIT writes the gray ramp; no other difference (ports, timing, FSM identical).

Test Plan:
- Release rst, hold wr_valid=1 throughout → busy=1 and wr_ready=0 for exactly 256 cycles; no write accepted until wr_ready=1, then busy=0.
- After INIT, gray ramp, en=1, r=g=b=255 → 2 cycles later outR=outG=outB=0xFF; r=g=b=0 → 0x00.
- Write addr 53 data 0x123456; next cycle drive r=255,g=0,b=0,en=1 (Y=53) → 2 cycles later out={0x12,0x34,0x56}.
- Same-cycle write of addr 53 (data 0xABCDEF) while a Y=53 pixel is in S1 → that pixel outputs the old entry; the following Y=53 pixel outputs 0xABCDEF.
- Alternate en=1/0 every pixel with pass_in=counter → outputs alternate mapped/bypass with no slip; pass_thru = pass_in delayed exactly 2.
- Assert rst for 1 cycle at INIT counter=100 → outputs 0 immediately (async); after release, INIT runs a full 256 cycles again.
- With PSEUDOCOLOR_HEATMAP_INIT_EN: en=1, r=g=b=0 → out 0x0000FF; r=g=b=255 → 0xFF0100.

Source files
------------

// File: rtl/pseudocolor.sv
// rtl/pseudocolor.sv - luminance-indexed palette pseudocolour filter; option macro PSEUDOCOLOR_HEATMAP_INIT_EN
module pseudocolor #(
    parameter int COEF_R = 54,
    parameter int COEF_G = 183,
    parameter int COEF_B = 19
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    input  logic [23:0] pass_in,
    output logic [7:0]  outR,
    output logic [7:0]  outG,
    output logic [7:0]  outB,
    output logic [23:0] pass_thru,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_addr,
    input  logic [23:0] wr_data,
    output logic        busy
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic [15:0] L_CR = 16'(COEF_R);
    localparam logic [15:0] L_CG = 16'(COEF_G);
    localparam logic [15:0] L_CB = 16'(COEF_B);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;

    logic [23:0] r_mem [256];
    logic        w_mem_we;
    logic [7:0]  w_mem_addr;
    logic [23:0] w_mem_data;
    logic [23:0] w_init_data;

    logic [15:0] w_sum;
    logic [7:0]  w_y;

    logic [7:0]  r_s1_y;
    logic [7:0]  r_s1_r, r_s1_g, r_s1_b;
    logic        r_s1_en;
    logic [23:0] r_s1_pass;

    logic [23:0] r_s2_pal;
    logic [7:0]  r_s2_r, r_s2_g, r_s2_b;
    logic        r_s2_en;
    logic [23:0] r_s2_pass;

    // Weights sum to 256, so the 16-bit sum never overflows and Y fits in 8 bits.
    assign w_sum = L_CR * {8'd0, r} + L_CG * {8'd0, g} + L_CB * {8'd0, b};
    assign w_y   = 8'(w_sum >> 8);

`ifdef PSEUDOCOLOR_HEATMAP_INIT_EN
    logic [8:0] w_twice;
    assign w_twice = {r_cnt, 1'b0};

    // Heat-map entry for the index being initialised: blue to green below 128, green to red above.
    always_comb begin
        w_init_data = 24'd0;
        if (!r_cnt[7]) begin
            w_init_data = {8'd0, w_twice[7:0], 8'(9'd255 - w_twice)};
        end else begin
            w_init_data = {8'(w_twice - 9'd255), 8'(9'd511 - w_twice), 8'd0};
        end
    end
`else
    // Gray-ramp entry for the index being initialised.
    always_comb begin
        w_init_data = {r_cnt, r_cnt, r_cnt};
    end
`endif

    // FSM state register; reset always restarts palette initialisation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: leave INIT once the last index has been written, RUN is terminal.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && r_cnt == 8'd255) begin
            w_state_nxt = ST_RUN;
        end
    end

    // FSM outputs: INIT owns the palette write port, RUN hands it to the external writer.
    always_comb begin
        busy       = 1'b1;
        wr_ready   = 1'b0;
        w_mem_we   = 1'b1;
        w_mem_addr = r_cnt;
        w_mem_data = w_init_data;
        if (r_state == ST_RUN) begin
            busy       = 1'b0;
            wr_ready   = 1'b1;
            w_mem_we   = wr_valid;
            w_mem_addr = wr_addr;
            w_mem_data = wr_data;
        end
    end

    // Init index counter, advancing one entry per cycle while initialising.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (r_state == ST_INIT) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Palette write port; contents are not reset, INIT rewrites every entry.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    // Two-stage pixel pipeline; the palette read sees the pre-write entry on a same-cycle collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_y    <= 8'd0;
            r_s1_r    <= 8'd0;
            r_s1_g    <= 8'd0;
            r_s1_b    <= 8'd0;
            r_s1_en   <= 1'b0;
            r_s1_pass <= 24'd0;
            r_s2_pal  <= 24'd0;
            r_s2_r    <= 8'd0;
            r_s2_g    <= 8'd0;
            r_s2_b    <= 8'd0;
            r_s2_en   <= 1'b0;
            r_s2_pass <= 24'd0;
        end else begin
            r_s1_y    <= w_y;
            r_s1_r    <= r;
            r_s1_g    <= g;
            r_s1_b    <= b;
            r_s1_en   <= en && (r_state == ST_RUN);
            r_s1_pass <= pass_in;
            r_s2_pal  <= r_mem[r_s1_y];
            r_s2_r    <= r_s1_r;
            r_s2_g    <= r_s1_g;
            r_s2_b    <= r_s1_b;
            r_s2_en   <= r_s1_en;
            r_s2_pass <= r_s1_pass;
        end
    end

    assign {outR, outG, outB} = r_s2_en ? r_s2_pal : {r_s2_r, r_s2_g, r_s2_b};
    assign pass_thru          = r_s2_pass;

endmodule

// File: tb/tb_pseudocolor.sv
// tb/tb_pseudocolor.sv - directed vector bench for pseudocolor
module tb_pseudocolor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  r = 8'd0, g = 8'd0, b = 8'd0;
    logic [23:0] pass_in = 24'd0;
    logic [7:0]  outR, outG, outB;
    logic [23:0] pass_thru;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  wr_addr = 8'd0;
    logic [23:0] wr_data = 24'd0;
    logic        busy;

    always #5 clk = ~clk;

    pseudocolor dut (
        .clk(clk), .rst(rst), .en(en), .r(r), .g(g), .b(b), .pass_in(pass_in),
        .outR(outR), .outG(outG), .outB(outB), .pass_thru(pass_thru),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy)
    );

    typedef struct {
        logic       en;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] y;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;

    logic        p1_c = 1'b0, p2_c = 1'b0;
    logic [23:0] p1_x, p2_x, p1_p, p2_p;
    string       p1_n, p2_n;

    function automatic logic [23:0] pal(input int i);
`ifdef PSEUDOCOLOR_HEATMAP_INIT_EN
        if (i < 128) pal = {8'd0, 8'(2 * i), 8'(255 - 2 * i)};
        else         pal = {8'(2 * i - 255), 8'(511 - 2 * i), 8'd0};
`else
        pal = {8'(i), 8'(i), 8'(i)};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Called at a negedge: checks the pixel applied two calls ago, drives a new one, waits one cycle.
    task automatic apply(input string nm, input logic c, input logic e, input logic [7:0] rr,
                         input logic [7:0] gg, input logic [7:0] bb, input logic [23:0] p,
                         input logic [23:0] x);
        if (p2_c) begin
            check(p2_n, {8'h0, outR, outG, outB}, {8'h0, p2_x});
            check({p2_n, "_pass"}, {8'h0, pass_thru}, {8'h0, p2_p});
        end
        p2_c = p1_c; p2_x = p1_x; p2_p = p1_p; p2_n = p1_n;
        p1_c = c;    p1_x = x;    p1_p = p;    p1_n = nm;
        en = e; r = rr; g = gg; b = bb; pass_in = p;
        @(negedge clk);
    endtask

    task automatic flush();
        apply("flush", 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 24'd0, 24'd0);
        apply("flush", 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 24'd0, 24'd0);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 400) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        vec_t        tbl [10];
        int          cnt;
        logic        bad;
        logic [23:0] ex;

        tbl[0] = '{1'b1, 8'd255, 8'd255, 8'd255, 8'd255};
        tbl[1] = '{1'b1, 8'd0,   8'd0,   8'd0,   8'd0};
        tbl[2] = '{1'b1, 8'd255, 8'd0,   8'd0,   8'd53};
        tbl[3] = '{1'b1, 8'd0,   8'd255, 8'd0,   8'd182};
        tbl[4] = '{1'b1, 8'd0,   8'd0,   8'd255, 8'd18};
        tbl[5] = '{1'b1, 8'd100, 8'd100, 8'd100, 8'd100};
        tbl[6] = '{1'b0, 8'd1,   8'd2,   8'd3,   8'd0};
        tbl[7] = '{1'b1, 8'd128, 8'd64,  8'd32,  8'd75};
        tbl[8] = '{1'b0, 8'd255, 8'd255, 8'd255, 8'd0};
        tbl[9] = '{1'b1, 8'd200, 8'd200, 8'd200, 8'd200};

        // Reset state with busy inputs.
        rst = 1'b1; en = 1'b1; r = 8'h12; g = 8'h34; b = 8'h56; pass_in = 24'h777;
        repeat (3) @(negedge clk);
        check("rst_out", {8'h0, outR, outG, outB}, 32'h0);
        check("rst_pass", {8'h0, pass_thru}, 32'h0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);

        // Release with a write held pending throughout INIT.
        wr_valid = 1'b1; wr_addr = 8'd200; wr_data = 24'hDEAD00;
        rst = 1'b0; en = 1'b0; r = 8'd0; g = 8'd0; b = 8'd0; pass_in = 24'd0;
        cnt = 0; bad = 1'b0;
        while (busy && cnt < 400) begin
            if (wr_ready) bad = 1'b1;
            if (cnt == 10) begin en = 1'b1; r = 8'd9; g = 8'd8; b = 8'd7; pass_in = 24'hABC; end
            if (cnt == 11) begin en = 1'b0; r = 8'd0; g = 8'd0; b = 8'd0; pass_in = 24'd0; end
            if (cnt == 12) begin
                check("init_bypass", {8'h0, outR, outG, outB}, 32'h090807);
                check("init_bypass_pass", {8'h0, pass_thru}, 32'hABC);
            end
            cnt++;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        check("init_len", 32'(cnt), 32'd256);
        check("init_no_ready", 32'(bad), 32'd0);
        check("run_wr_ready", 32'(wr_ready), 32'd1);
        check("run_busy", 32'(busy), 32'd0);

        // Table of default-palette and bypass vectors.
        for (int i = 0; i < 10; i++) begin
            ex = tbl[i].en ? pal(int'(tbl[i].y)) : {tbl[i].r, tbl[i].g, tbl[i].b};
            apply($sformatf("vec%0d", i), 1'b1, tbl[i].en, tbl[i].r, tbl[i].g, tbl[i].b,
                  24'(i * 3 + 1), ex);
        end
        flush();

        // Write then use on the following cycle.
        wr_valid = 1'b1; wr_addr = 8'd53; wr_data = 24'h123456;
        @(negedge clk);
        wr_valid = 1'b0;
        apply("wr_visible", 1'b1, 1'b1, 8'd255, 8'd0, 8'd0, 24'h5, 24'h123456);
        flush();

        // Same-cycle read and write of the same index.
        apply("rbw_old", 1'b1, 1'b1, 8'd255, 8'd0, 8'd0, 24'h6, 24'h123456);
        wr_valid = 1'b1; wr_addr = 8'd53; wr_data = 24'hABCDEF;
        apply("rbw_new", 1'b1, 1'b1, 8'd255, 8'd0, 8'd0, 24'h7, 24'hABCDEF);
        wr_valid = 1'b0;
        flush();

        // Alternating en with a counting sideband.
        for (int i = 0; i < 8; i++) begin
            apply($sformatf("alt%0d", i), 1'b1, ~i[0], 8'd255, 8'd0, 8'd0, 24'(100 + i),
                  i[0] ? 24'hFF0000 : 24'hABCDEF);
        end
        flush();

        // Reset from RUN clears outputs asynchronously.
        apply("hold", 1'b0, 1'b0, 8'h11, 8'h22, 8'h33, 24'h444, 24'd0);
        apply("hold", 1'b0, 1'b0, 8'h11, 8'h22, 8'h33, 24'h444, 24'd0);
        rst = 1'b1;
        #1;
        check("async_rst_out", {8'h0, outR, outG, outB}, 32'h0);
        check("async_rst_pass", {8'h0, pass_thru}, 32'h0);
        check("async_rst_busy", 32'(busy), 32'd1);
        p1_c = 1'b0; p2_c = 1'b0;
        @(negedge clk);
        rst = 1'b0; en = 1'b1; r = 8'h55; g = 8'h55; b = 8'h55; pass_in = 24'h999;
        repeat (100) @(negedge clk);
        check("init_en_ignored", {8'h0, outR, outG, outB}, 32'h555555);

        // Reset mid-INIT at counter 100 restarts the full init.
        rst = 1'b1;
        #1;
        check("midinit_rst_out", {8'h0, outR, outG, outB}, 32'h0);
        @(negedge clk);
        rst = 1'b0; en = 1'b0; r = 8'd0; g = 8'd0; b = 8'd0; pass_in = 24'd0;
        count_busy(cnt);
        check("reinit_len", 32'(cnt), 32'd256);

        // Loaded entry discarded by the re-init.
        apply("reinit_53", 1'b1, 1'b1, 8'd255, 8'd0, 8'd0, 24'h8, pal(53));
        apply("reinit_255", 1'b1, 1'b1, 8'd255, 8'd255, 8'd255, 24'h9, pal(255));
        apply("reinit_0", 1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 24'hA, pal(0));
        flush();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
